// File: rtl/prio_disp_sched.sv
// Debounced 16-input priority dispatcher with grant/ack handshake and a two-digit
// multiplexed 7-segment readout of the granted index. PRIO_DISP_SCHED_ROUND_ROBIN_EN selects round-robin.
module prio_disp_sched #(
   parameter int DEB_CYC  = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req_n,
   input  logic        grant_ack,
   output logic        grant_vld,
   output logic [3:0]  grant_code,
   output logic        busy,
   output logic [7:0]  seg,
   output logic [1:0]  dig_sel
);

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [7:0] DEB_LAST = 8'(DEB_CYC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      GRANT   = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic [15:0]       req_meta_r, req_sync_r, req_s;
   logic [3:0]        cand_s, latch_r, latch_s, code_r, code_s;
   logic [7:0]        cnt_r, cnt_s;
   logic              vld_r, vld_s, busy_r;
   logic [SCAN_W-1:0] scan_r, scan_s;
   logic [1:0]        dig_r, dig_s;
   logic [7:0]        seg_r, seg_s;

   function automatic logic [6:0] seg_digit(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   function automatic logic [3:0] pick_high(input logic [15:0] r);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (r[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign req_s = ~req_sync_r;

`ifdef PRIO_DISP_SCHED_ROUND_ROBIN_EN
   logic [3:0]  ptr_r;
   logic [31:0] rot_s;

   function automatic logic [3:0] pick_low(input logic [15:0] r);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (r[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Rotate the request vector so the search starts at ptr, then map back.
   always_comb begin
      rot_s  = {req_s, req_s} >> ptr_r;
      cand_s = ptr_r + pick_low(rot_s[15:0]);
   end

   // Pointer moves past the winner on every grant entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= 4'd0;
      end else if (state_r == SETTLE && state_s == GRANT) begin
         ptr_r <= latch_r + 4'd1;
      end else begin
         ptr_r <= ptr_r;
      end
   end
`else
   assign cand_s = pick_high(req_s);
`endif

   // FSM next state, stable counter and grant outputs.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      latch_s = latch_r;
      code_s  = code_r;
      vld_s   = vld_r;
      case (state_r)
         IDLE: begin
            if (req_s != 16'h0000) begin
               state_s = SETTLE;
               cnt_s   = 8'd1;
               latch_s = cand_s;
            end else begin
               cnt_s = 8'd0;
            end
         end
         SETTLE: begin
            if (req_s == 16'h0000) begin
               state_s = IDLE;
               cnt_s   = 8'd0;
            end else if (cand_s != latch_r) begin
               latch_s = cand_s;
               cnt_s   = 8'd1;
            end else if (cnt_r >= DEB_LAST) begin
               state_s = GRANT;
               code_s  = latch_r;
               vld_s   = 1'b1;
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         GRANT: begin
            if (grant_ack) begin
               state_s = RELEASE;
               vld_s   = 1'b0;
            end else begin
               vld_s = 1'b1;
            end
         end
         RELEASE: begin
            if (!req_s[code_r]) begin
               state_s = IDLE;
               cnt_s   = 8'd0;
            end else begin
               state_s = RELEASE;
            end
         end
         default: begin
            state_s = IDLE;
            vld_s   = 1'b0;
         end
      endcase
   end

   // Digit scan and segment image computed for the values the registers take next,
   // so seg always matches dig_sel and the grant in the same cycle.
   always_comb begin
      if (scan_r == SCAN_LAST) begin
         scan_s = '0;
         dig_s  = {dig_r[0], dig_r[1]};
      end else begin
         scan_s = scan_r + SCAN_W'(1);
         dig_s  = dig_r;
      end
      if (!vld_s) begin
         seg_s = 8'h00;
      end else if (dig_s == 2'b01) begin
         seg_s = {1'b0, seg_digit(4'(code_s % 4'd10))};
      end else begin
         seg_s = (code_s >= 4'd10) ? 8'h06 : 8'h00;
      end
   end

   // State, synchronizer and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_meta_r <= 16'hFFFF;
         req_sync_r <= 16'hFFFF;
         state_r    <= IDLE;
         cnt_r      <= 8'd0;
         latch_r    <= 4'd0;
         code_r     <= 4'd0;
         vld_r      <= 1'b0;
         busy_r     <= 1'b0;
         scan_r     <= '0;
         dig_r      <= 2'b01;
         seg_r      <= 8'h00;
      end else begin
         req_meta_r <= req_n;
         req_sync_r <= req_meta_r;
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         latch_r    <= latch_s;
         code_r     <= code_s;
         vld_r      <= vld_s;
         busy_r     <= (state_s != IDLE);
         scan_r     <= scan_s;
         dig_r      <= dig_s;
         seg_r      <= seg_s;
      end
   end

   assign grant_vld  = vld_r;
   assign grant_code = code_r;
   assign busy       = busy_r;
   assign seg        = seg_r;
   assign dig_sel    = dig_r;

endmodule
